// File: rtl/aes_key_schedule_dec_if.sv
// Key-schedule bus: key loading from the key-input side, round-key reads from the decryptor.
interface aes_key_schedule_dec_if;
    logic [127:0] key_in;
    logic         key_load;
    logic         key_busy;
    logic         keys_ready;
    logic [3:0]   rk_sel;
    logic         rk_req;
    logic [127:0] round_key;
    logic         rk_valid;

    modport master (
        output key_in, key_load, rk_sel, rk_req,
        input  key_busy, keys_ready, round_key, rk_valid
    );

    modport slave (
        input  key_in, key_load, rk_sel, rk_req,
        output key_busy, keys_ready, round_key, rk_valid
    );
endinterface

// File: rtl/aes_key_schedule_dec.sv
// AES-128 key expansion, one round per cycle into a key store, with indexed round-key reads
// so the decryptor can walk rounds NR down to 0.
module aes_key_schedule_dec #(
    parameter int unsigned NR              = 10,
    parameter bit          ZERO_ON_BAD_SEL = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    aes_key_schedule_dec_if.slave  key_if
);

    localparam int unsigned NKEYS = NR + 1;
    localparam int unsigned CW    = 4;

    // Forward S-box, entry 0 first.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_READY
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_load_ok;
    logic            w_last_round;

    logic [127:0]    r_store [NKEYS];
    logic [127:0]    r_work;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_rcon;

    logic            r_key_busy;
    logic            r_keys_ready;
    logic            r_rk_valid;
    logic [127:0]    r_round_key;

    logic [31:0]     w_rot;
    logic [31:0]     w_temp;
    logic [31:0]     w_w0;
    logic [31:0]     w_w1;
    logic [31:0]     w_w2;
    logic [31:0]     w_w3;
    logic [127:0]    w_next_key;
    logic [127:0]    w_read_key;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: loads accepted only outside EXPAND; leave EXPAND after writing key NR.
    always_comb begin
        w_state_next = r_state;
        w_load_ok    = 1'b0;
        w_last_round = 1'b0;
        case (r_state)
            ST_IDLE, ST_READY: begin
                if (key_if.key_load) begin
                    w_state_next = ST_EXPAND;
                    w_load_ok    = 1'b1;
                end
            end
            ST_EXPAND: begin
                if (r_cnt == CW'(NR)) begin
                    w_state_next = ST_READY;
                    w_last_round = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // One key-expansion round from the previous round key held in r_work.
    always_comb begin
        w_rot      = {r_work[23:0], r_work[31:24]};
        w_temp     = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])}
                     ^ {r_rcon, 24'h000000};
        w_w0       = r_work[127:96] ^ w_temp;
        w_w1       = r_work[95:64]  ^ w_w0;
        w_w2       = r_work[63:32]  ^ w_w1;
        w_w3       = r_work[31:0]   ^ w_w2;
        w_next_key = {w_w0, w_w1, w_w2, w_w3};
    end

    // Round counter, rcon and working key register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_rcon <= 8'h01;
            r_work <= '0;
        end else if (w_load_ok) begin
            r_cnt  <= CW'(1);
            r_rcon <= 8'h01;
            r_work <= key_if.key_in;
        end else if (r_state == ST_EXPAND && !w_last_round) begin
            r_cnt  <= r_cnt + CW'(1);
            r_rcon <= xtime(r_rcon);
            r_work <= w_next_key;
        end
    end

    // Key store; contents are meaningless until keys_ready, so no reset.
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_store[0] <= key_if.key_in;
        end else if (r_state == ST_EXPAND) begin
            r_store[r_cnt] <= w_next_key;
        end
    end

    // Read mux, with the out-of-range policy.
    always_comb begin
        w_read_key = '0;
        if (key_if.rk_sel <= CW'(NR)) begin
            w_read_key = r_store[key_if.rk_sel];
        end else if (!ZERO_ON_BAD_SEL) begin
            w_read_key = r_store[NR];
        end
    end

    // Registered status flags and round-key read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_busy   <= 1'b0;
            r_keys_ready <= 1'b0;
            r_rk_valid   <= 1'b0;
            r_round_key  <= '0;
        end else begin
            r_key_busy   <= (w_state_next == ST_EXPAND);
            r_keys_ready <= (w_state_next == ST_READY);
            r_rk_valid   <= 1'b0;
            if (key_if.rk_req && r_keys_ready) begin
                r_rk_valid  <= 1'b1;
                r_round_key <= w_read_key;
            end
        end
    end

    assign key_if.key_busy   = r_key_busy;
    assign key_if.keys_ready = r_keys_ready;
    assign key_if.rk_valid   = r_rk_valid;
    assign key_if.round_key  = r_round_key;

endmodule

// File: tb/tb_aes_key_schedule_dec.sv
// Directed bench for aes_key_schedule_dec using FIPS-197 key-expansion vectors.
module tb_aes_key_schedule_dec;

    localparam logic [127:0] K1      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1_RK1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] K1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K2      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K2_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    aes_key_schedule_dec_if bus ();

    aes_key_schedule_dec #(
        .NR              (10),
        .ZERO_ON_BAD_SEL (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%032h exp=%032h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for keys_ready and checks how many cycles it took.
    task automatic wait_ready(input string tag, input int exp_ticks);
        int n = 0;
        while (!bus.keys_ready && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 128'(n), 128'(exp_ticks));
    endtask

    task automatic load_key(input logic [127:0] k);
        bus.key_in   = k;
        bus.key_load = 1'b1;
        tick();
        bus.key_load = 1'b0;
    endtask

    task automatic read_key(input logic [3:0] sel, input string tag, input logic [127:0] exp);
        bus.rk_sel = sel;
        bus.rk_req = 1'b1;
        tick();
        bus.rk_req = 1'b0;
        chk({tag, "_valid"}, 128'(bus.rk_valid), 128'(1));
        chk(tag, bus.round_key, exp);
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst          = 1'b1;
        bus.key_in   = '0;
        bus.key_load = 1'b0;
        bus.rk_sel   = '0;
        bus.rk_req   = 1'b0;
        tick();
        tick();
        chk("rst_busy",  128'(bus.key_busy),   128'(0));
        chk("rst_ready", 128'(bus.keys_ready), 128'(0));
        chk("rst_valid", 128'(bus.rk_valid),   128'(0));
        chk("rst_rk",    bus.round_key,        128'(0));
        rst = 1'b0;

        // Request before any key is expanded is ignored.
        bus.rk_req = 1'b1;
        tick();
        bus.rk_req = 1'b0;
        chk("idle_req_valid", 128'(bus.rk_valid), 128'(0));

        // Key 1: busy exactly 10 cycles, ready at load+11.
        load_key(K1);
        for (int i = 0; i < 10; i++) begin
            chk("k1_busy", 128'(bus.key_busy), 128'(1));
            chk("k1_notready", 128'(bus.keys_ready), 128'(0));
            tick();
        end
        chk("k1_busy_end", 128'(bus.key_busy), 128'(0));
        chk("k1_ready", 128'(bus.keys_ready), 128'(1));
        read_key(4'd10, "k1_rk10", K1_RK10);
        tick();
        chk("k1_valid_drop", 128'(bus.rk_valid), 128'(0));
        chk("k1_rk_hold", bus.round_key, K1_RK10);
        read_key(4'd1, "k1_rk1", K1_RK1);

        // Key 2: stream indices 10 down to 0 back to back.
        load_key(K2);
        wait_ready("k2_latency", 10);
        bus.rk_req = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            bus.rk_sel = 4'(10 - i);
            tick();
            chk("k2_stream_valid", 128'(bus.rk_valid), 128'(1));
            if (i == 0)  chk("k2_rk10", bus.round_key, K2_RK10);
            if (i == 9)  chk("k2_rk1",  bus.round_key, K2_RK1);
            if (i == 10) chk("k2_rk0",  bus.round_key, K2);
        end
        bus.rk_req = 1'b0;
        tick();
        chk("k2_stream_end", 128'(bus.rk_valid), 128'(0));

        // Reload key 1; reads during EXPAND and a second load in cycle 5 are ignored.
        load_key(K1);
        bus.rk_sel = 4'd10;
        bus.rk_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 5) begin
                bus.key_in   = K2;
                bus.key_load = 1'b1;
            end else begin
                bus.key_load = 1'b0;
            end
            tick();
            chk("exp_req_valid", 128'(bus.rk_valid), 128'(0));
        end
        chk("exp_ready", 128'(bus.keys_ready), 128'(1));
        tick();
        bus.rk_req = 1'b0;
        chk("exp_first_valid", 128'(bus.rk_valid), 128'(1));
        chk("exp_rk10_k1", bus.round_key, K1_RK10);
        read_key(4'd1, "exp_rk1_k1", K1_RK1);

        // Load in READY with simultaneous read: old key served, new keys follow.
        bus.key_in   = K2;
        bus.key_load = 1'b1;
        bus.rk_sel   = 4'd10;
        bus.rk_req   = 1'b1;
        tick();
        bus.key_load = 1'b0;
        bus.rk_req   = 1'b0;
        chk("reload_valid", 128'(bus.rk_valid), 128'(1));
        chk("reload_old_rk10", bus.round_key, K1_RK10);
        chk("reload_ready_low", 128'(bus.keys_ready), 128'(0));
        wait_ready("reload_latency", 10);
        read_key(4'd10, "reload_new_rk10", K2_RK10);

        // Out-of-range index returns zero.
        read_key(4'd12, "bad_sel12", 128'(0));
        read_key(4'd15, "bad_sel15", 128'(0));
        read_key(4'd0,  "k2_rk0_again", K2);

        // Reset in cycle 4 of EXPAND.
        load_key(K1);
        tick();
        tick();
        chk("pre_rst_busy", 128'(bus.key_busy), 128'(1));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy",  128'(bus.key_busy),   128'(0));
        chk("midrst_ready", 128'(bus.keys_ready), 128'(0));
        chk("midrst_valid", 128'(bus.rk_valid),   128'(0));
        chk("midrst_rk",    bus.round_key,        128'(0));
        bus.rk_req = 1'b1;
        tick();
        bus.rk_req = 1'b0;
        chk("midrst_req_ignored", 128'(bus.rk_valid), 128'(0));
        load_key(K2);
        wait_ready("post_rst_latency", 10);
        read_key(4'd10, "post_rst_rk10", K2_RK10);
        read_key(4'd1,  "post_rst_rk1",  K2_RK1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule_dec.md
Name: aes_key_schedule_dec

Overview:
- Sequential AES-128 key-expansion stage that feeds the decryptor's round-key XOR stage.
- Accepts one 128-bit cipher key and expands all 11 round keys at one round per cycle into an internal key store.
- Serves any stored round key by index so the decryptor can walk rounds 10 down to 0.
- Sits between the key-input interface and the decryptor datapath's add-round-key operand.

Parameters:
- NR, 10, number of expansion rounds; only 10 (AES-128) is legal, and the key store holds NR+1 entries.
- ZERO_ON_BAD_SEL, 1, if 1 an out-of-range rk_sel returns all-zero round_key; if 0 it returns round key NR.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- key_in  input  128  cipher key; bits [127:120] = byte 0, word w0 = [127:96].
- key_load  input  1  single-cycle request to start expansion of key_in.
- key_busy  output  1  high while expansion is in progress.
- keys_ready  output  1  high when all 11 round keys are valid in the store.
- rk_sel  input  4  round-key index 0..10.
- rk_req  input  1  read strobe for round key rk_sel.
- round_key  output  128  registered round key, to the add-round-key stage.
- rk_valid  output  1  one-cycle pulse; round_key is valid while it is high.

Behaviour:
- Reset: state IDLE; key_busy=0, keys_ready=0, rk_valid=0, round_key=0, round counter=0, rcon=8'h01. Key-store contents are don't-care after reset.
- The FSM has three states: IDLE, EXPAND, READY.
- IDLE or READY with key_load=1 at edge t:
  - store[0] <= key_in.
  - Go to EXPAND, set counter=1, rcon=01, key_busy=1, keys_ready=0 (both visible from cycle t+1).
- EXPAND, cycle k (k=1..10):
  - Compute store[k] from store[k-1]: temp = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0'=w0^temp; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - RotWord rotates the bytes left: [a0 a1 a2 a3] -> [a1 a2 a3 a0].
  - SubWord uses four forward S-box lookups. The lookup is combinational, from store[k-1] held in a working register.
  - rcon advances by xtime each round: 01,02,04,08,10,20,40,80,1B,36.
  - After writing store[10]: go to READY, key_busy=0, keys_ready=1.
  - A key_load accepted at edge t therefore gives keys_ready=1 from cycle t+11.
- key_load while in EXPAND: ignored; expansion continues unchanged.
- key_load in READY: restarts expansion; keys_ready falls the next cycle. A simultaneous rk_req in that cycle is still served from the old store.
- Read path:
  - rk_req=1 with keys_ready=1 at edge t: round_key <= store[rk_sel] and rk_valid=1 during cycle t+1. Latency is 1; back-to-back requests give one key per cycle.
  - rk_req with keys_ready=0: ignored; rk_valid stays 0 and round_key holds its value.
  - rk_sel>10: follows ZERO_ON_BAD_SEL; rk_valid still pulses.
  - round_key holds its last value between requests; rk_valid is 0 in any cycle without a served request.
- rst mid-EXPAND: returns to IDLE the next cycle, outputs go to their reset values, and partial keys are discarded.
- All XORs are bitwise at 128/32/8 bits with no carries. rcon xtime: {r[6:0],1'b0} ^ (r[7] ? 8'h1B : 8'h00).

Test Plan:
- Load 000102030405060708090a0b0c0d0e0f -> key_busy high for exactly 10 cycles; keys_ready=1 at load+11. rk_sel=10 gives 13111d7fe3944a17f307a78b4d2b30c5; rk_sel=1 gives d6aa74fdd2af72fadaa678f1d6ab76fe.
- Load 2b7e151628aed2a6abf7158809cf4f3c, then request indices 10 down to 0 on consecutive cycles -> 11 back-to-back rk_valid pulses. First value d014f9a8c9ee2589e13f0cc8b6630ca6; 10th value a0fafe1788542cb123a339392a6c7605; last value equals key_in.
- rk_req during EXPAND, and key_load issued at cycle 5 of EXPAND -> no rk_valid, the second key_load is ignored, and keys match the first key.
- In READY, key_load with a new key plus a simultaneous rk_req sel=10 -> the old round key 10 is returned. keys_ready=0 next cycle, and the new keys are correct after 11 cycles.
- rk_sel=12 with ZERO_ON_BAD_SEL=1 -> rk_valid=1, round_key=0.
- Assert rst at cycle 4 of EXPAND -> all outputs 0 next cycle, state IDLE. A new load then completes normally.
